// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS: waveform mode encodings,
// register map offsets and the full-scale amplitude value.
package dds_pkg;

    localparam logic [1:0] MODE_SINE   = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_SAW    = 2'd3;

    localparam int REG_CTRL   = 'h00;
    localparam int REG_SYNC   = 'h01;
    localparam int CH_BASE    = 'h20;
    localparam int CH_STRIDE  = 'h10;

    localparam int OFF_FTW_LO = 0;
    localparam int OFF_FTW_HI = 1;
    localparam int OFF_POFF   = 2;
    localparam int OFF_AMP    = 3;
    localparam int OFF_MODE   = 4;

    localparam int AMP_FULL   = 256;

endpackage

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine ROM with a registered read port. Entry k holds
// round(A*sin(pi/2*k/Q)) for k = 0..Q; the sign and mirroring for the other
// quadrants are handled by the caller.
module dds_sine_lut
    import dds_pkg::*;
#(
    parameter int PH_W  = 10,
    parameter int OUT_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PH_W-2:0]   addr,
    output logic [OUT_W-2:0]  data
);

    localparam int Q = 1 << (PH_W - 2);
    localparam int A = (1 << (OUT_W - 1)) - 1;

    function automatic logic [OUT_W-2:0] sine_entry(input int k);
        real x;
        x = real'(A) * $sin(3.141592653589793 / 2.0 * real'(k) / real'(Q)) + 0.5;
        return (OUT_W-1)'($rtoi(x));
    endfunction

    logic [OUT_W-2:0] rom [0:Q];

    for (genvar k = 0; k <= Q; k++) begin : g_rom
        assign rom[k] = sine_entry(k);
    end

    // Registered ROM read
    always_ff @(posedge clk) begin
        if (rst) data <= '0;
        else     data <= rom[addr];
    end

endmodule

// File: rtl/dds_multi_ch.sv
// Multi-channel DDS generator. Each channel runs its own phase accumulator
// and a 4-stage pipeline: phase add, wave select / LUT read, amplitude
// multiply, output gating. Mode and amplitude travel with each sample so
// configuration writes never alter samples already in flight.
module dds_multi_ch
    import dds_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int ACC_W  = 32,
    parameter int PH_W   = 10,
    parameter int OUT_W  = 13,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    output logic [NCH*OUT_W-1:0]   dout,
    output logic [NCH-1:0]         out_valid
);

    localparam int A     = (1 << (OUT_W - 1)) - 1;
    localparam int Q     = 1 << (PH_W - 2);
    localparam int HALF  = 1 << (PH_W - 1);
    localparam int SLOPE = (4 * A) >> PH_W;

    logic [NCH-1:0] ctrl;
    logic           sync_hit;

    assign sync_hit = wr && (waddr == ADDR_W'(REG_SYNC)) && wdata[0];

    // Channel enable register
    always_ff @(posedge clk) begin
        if (rst)                                    ctrl <= '0;
        else if (wr && waddr == ADDR_W'(REG_CTRL))  ctrl <= wdata[NCH-1:0];
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [ADDR_W-1:0] BASE = ADDR_W'(CH_BASE + CH_STRIDE * c);

        logic [ACC_W-1:0]        acc, ftw;
        logic [DATA_W-1:0]       ftw_lo;
        logic [PH_W-1:0]         poff;
        logic [8:0]              amp;
        logic [1:0]              mode;

        logic [PH_W-1:0]         p1;
        logic [8:0]              amp1, amp2;
        logic [1:0]              mode1, mode2;
        logic                    v1, v2, v3, v4;

        logic [PH_W-2:0]         lut_addr;
        logic [OUT_W-2:0]        lut2;
        logic signed [OUT_W-1:0] alt, alt2, lut_s, wave2, y3, y4;
        logic                    neg2;
        int                      tri_v;
        logic signed [OUT_W+7:0] wave_x, amp_x;

        // Per-channel configuration registers; FTW_HI commits the shadowed low half
        always_ff @(posedge clk) begin
            if (rst) begin
                ftw_lo <= '0;
                ftw    <= '0;
                poff   <= '0;
                amp    <= 9'(AMP_FULL);
                mode   <= MODE_SINE;
            end else if (wr) begin
                if (waddr == BASE + ADDR_W'(OFF_FTW_LO)) ftw_lo <= wdata;
                if (waddr == BASE + ADDR_W'(OFF_FTW_HI)) ftw    <= ACC_W'({wdata, ftw_lo});
                if (waddr == BASE + ADDR_W'(OFF_POFF))   poff   <= wdata[PH_W-1:0];
                if (waddr == BASE + ADDR_W'(OFF_AMP))
                    amp <= (wdata > DATA_W'(AMP_FULL)) ? 9'(AMP_FULL) : wdata[8:0];
                if (waddr == BASE + ADDR_W'(OFF_MODE))   mode   <= wdata[1:0];
            end
        end

        // Phase accumulator, held at zero while disabled or on SYNC
        always_ff @(posedge clk) begin
            if (rst || !ctrl[c] || sync_hit) acc <= '0;
            else                             acc <= acc + ftw;
        end

        // Stage 1: truncated phase plus offset, capture per-sample config
        always_ff @(posedge clk) begin
            if (rst) begin
                p1 <= '0; amp1 <= '0; mode1 <= MODE_SINE; v1 <= 1'b0;
            end else begin
                p1    <= acc[ACC_W-1 -: PH_W] + poff;
                amp1  <= amp;
                mode1 <= mode;
                v1    <= ctrl[c];
            end
        end

        assign lut_addr = p1[PH_W-2] ? (PH_W-1)'(Q) - {1'b0, p1[PH_W-3:0]}
                                     : {1'b0, p1[PH_W-3:0]};

        // Non-sine waveforms computed directly from the phase
        always_comb begin
            tri_v = 0;
            if (!p1[PH_W-1]) tri_v = -A + SLOPE * int'(p1);
            else             tri_v =  A - SLOPE * (int'(p1) - HALF);
            alt = '0;
            case (mode1)
                MODE_SQUARE: alt = p1[PH_W-1] ? OUT_W'(-A) : OUT_W'(A);
                MODE_TRI:    alt = OUT_W'(tri_v);
                default:     alt = {~p1[PH_W-1], p1[PH_W-2:0], {(OUT_W-PH_W){1'b0}}};
            endcase
        end

        dds_sine_lut #(
            .PH_W  (PH_W),
            .OUT_W (OUT_W)
        ) u_lut (
            .clk  (clk),
            .rst  (rst),
            .addr (lut_addr),
            .data (lut2)
        );

        // Stage 2: LUT read in flight, register alternate waveform and sign
        always_ff @(posedge clk) begin
            if (rst) begin
                alt2 <= '0; neg2 <= 1'b0; amp2 <= '0; mode2 <= MODE_SINE; v2 <= 1'b0;
            end else begin
                alt2  <= alt;
                neg2  <= p1[PH_W-1];
                amp2  <= amp1;
                mode2 <= mode1;
                v2    <= v1;
            end
        end

        assign lut_s  = {1'b0, lut2};
        assign wave2  = (mode2 == MODE_SINE) ? (neg2 ? -lut_s : lut_s) : alt2;
        assign wave_x = (OUT_W+8)'(wave2);
        assign amp_x  = (OUT_W+8)'(amp2);

        // Stage 3: amplitude scaling with floor shift
        always_ff @(posedge clk) begin
            if (rst) begin
                y3 <= '0; v3 <= 1'b0;
            end else begin
                y3 <= OUT_W'((wave_x * amp_x) >>> 8);
                v3 <= v2;
            end
        end

        // Stage 4: output register, zeroed whenever the sample is not valid
        always_ff @(posedge clk) begin
            if (rst) begin
                y4 <= '0; v4 <= 1'b0;
            end else begin
                y4 <= v3 ? y3 : '0;
                v4 <= v3;
            end
        end

        assign dout[c*OUT_W +: OUT_W] = y4;
        assign out_valid[c]           = v4;
    end

endmodule
